// File: rtl/ahb_decoder_mux_pkg.sv
// Shared AHB subordinate definitions: region indices, transfer and response
// encodings, the region-select encoding and the data-phase state type.
package ahb_decoder_mux_pkg;

   // Values of HADDR[ADDR_WIDTH-1:16] that map to the real subordinates
   localparam int REGION_S0 = 0;
   localparam int REGION_S1 = 1;
   localparam int REGION_S2 = 2;

   // HTRANS encodings
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   // HRESP encodings
   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   // Region select: which subordinate owns an address or a data phase
   typedef enum logic [1:0] {
      SEL_S0  = 2'd0,
      SEL_S1  = 2'd1,
      SEL_S2  = 2'd2,
      SEL_DEF = 2'd3
   } sel_e;

   // Data-phase tracker: DATA means a NONSEQ/SEQ transfer is in its data phase
   typedef enum logic {
      ST_NODATA = 1'b0,
      ST_DATA   = 1'b1
   } state_e;

endpackage

// File: rtl/ahb_decoder_mux_if.sv
// Bus bundle between the manager, the decoder/mux and the subordinates.
// Handshake: an address phase (HADDR/HTRANS) is taken on every rising edge
// where HREADY=1; HREADY=0 stretches the current data phase and the manager
// must treat the address phase as not yet accepted.
interface ahb_decoder_mux_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] HADDR;
   logic [1:0]            HTRANS;

   logic                  HSEL_S0;
   logic                  HSEL_S1;
   logic                  HSEL_S2;
   logic                  HSEL_DEF;

   logic [DATA_WIDTH-1:0] HRDATA_S0;
   logic [DATA_WIDTH-1:0] HRDATA_S1;
   logic [DATA_WIDTH-1:0] HRDATA_S2;
   logic [DATA_WIDTH-1:0] HRDATA_DEF;
   logic [1:0]            HRESP_S0;
   logic [1:0]            HRESP_S1;
   logic [1:0]            HRESP_S2;
   logic [1:0]            HRESP_DEF;
   logic                  HREADYOUT_S0;
   logic                  HREADYOUT_S1;
   logic                  HREADYOUT_S2;
   logic                  HREADYOUT_DEF;

   logic [DATA_WIDTH-1:0] HRDATA;
   logic [1:0]            HRESP;
   logic                  HREADY;

   // Decoder/mux side
   modport slave (
      input  HADDR, HTRANS,
      input  HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_DEF,
      input  HRESP_S0, HRESP_S1, HRESP_S2, HRESP_DEF,
      input  HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_DEF,
      output HSEL_S0, HSEL_S1, HSEL_S2, HSEL_DEF,
      output HRDATA, HRESP, HREADY
   );

   // Manager plus subordinates side
   modport master (
      output HADDR, HTRANS,
      output HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_DEF,
      output HRESP_S0, HRESP_S1, HRESP_S2, HRESP_DEF,
      output HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_DEF,
      input  HSEL_S0, HSEL_S1, HSEL_S2, HSEL_DEF,
      input  HRDATA, HRESP, HREADY
   );
endinterface

// File: rtl/ahb_resp_mux.sv
// Combinational response multiplexer: routes the data-phase owner's read
// data, response and ready back to the manager; idles to OKAY/ready when no
// data phase is in progress.
module ahb_resp_mux
   import ahb_decoder_mux_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  active_i,
   input  sel_e                  sel_i,
   input  logic [DATA_WIDTH-1:0] hrdata_s0_i,
   input  logic [DATA_WIDTH-1:0] hrdata_s1_i,
   input  logic [DATA_WIDTH-1:0] hrdata_s2_i,
   input  logic [DATA_WIDTH-1:0] hrdata_def_i,
   input  logic [1:0]            hresp_s0_i,
   input  logic [1:0]            hresp_s1_i,
   input  logic [1:0]            hresp_s2_i,
   input  logic [1:0]            hresp_def_i,
   input  logic                  hreadyout_s0_i,
   input  logic                  hreadyout_s1_i,
   input  logic                  hreadyout_s2_i,
   input  logic                  hreadyout_def_i,
   output logic [DATA_WIDTH-1:0] hrdata_o,
   output logic [1:0]            hresp_o,
   output logic                  hready_o
);

   // Select the registered data-phase owner; zero latency from subordinate
   always_comb begin
      hrdata_o = '0;
      hresp_o  = HRESP_OKAY;
      hready_o = 1'b1;
      if (active_i) begin
         unique case (sel_i)
            SEL_S0: begin
               hrdata_o = hrdata_s0_i;
               hresp_o  = hresp_s0_i;
               hready_o = hreadyout_s0_i;
            end
            SEL_S1: begin
               hrdata_o = hrdata_s1_i;
               hresp_o  = hresp_s1_i;
               hready_o = hreadyout_s1_i;
            end
            SEL_S2: begin
               hrdata_o = hrdata_s2_i;
               hresp_o  = hresp_s2_i;
               hready_o = hreadyout_s2_i;
            end
            default: begin
               hrdata_o = hrdata_def_i;
               hresp_o  = hresp_def_i;
               hready_o = hreadyout_def_i;
            end
         endcase
      end
   end

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB address decoder and response mux for three subordinates plus a default
// subordinate, with a saturating count of transfers that hit the default.
module ahb_decoder_mux
   import ahb_decoder_mux_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   ahb_decoder_mux_if.slave     bus,
   output logic [7:0]           DECERR_CNT,
   output state_e               dbg_state_o
);

   localparam int RW = ADDR_WIDTH - 16;

   logic [RW-1:0] region;
   sel_e          dec_sel;
   logic          accept;
   logic          hready;
   state_e        state_q, state_d;
   sel_e          sel_q, sel_d;
   logic [7:0]    decerr_q, decerr_d;
   logic          unused_addr_bits;

   assign region           = bus.HADDR[ADDR_WIDTH-1:16];
   assign unused_addr_bits = ^{bus.HADDR[15:0], bus.HTRANS[0]};

   // Address decode on the upper address bits; always exactly one target
   always_comb begin
      dec_sel = SEL_DEF;
      if (region == RW'(REGION_S0))      dec_sel = SEL_S0;
      else if (region == RW'(REGION_S1)) dec_sel = SEL_S1;
      else if (region == RW'(REGION_S2)) dec_sel = SEL_S2;
   end

   assign bus.HSEL_S0  = (dec_sel == SEL_S0);
   assign bus.HSEL_S1  = (dec_sel == SEL_S1);
   assign bus.HSEL_S2  = (dec_sel == SEL_S2);
   assign bus.HSEL_DEF = (dec_sel == SEL_DEF);

   assign accept = hready;

   // Next state: on acceptance capture the target and whether a data phase follows
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      decerr_d = decerr_q;
      if (accept) begin
         sel_d   = dec_sel;
         state_d = bus.HTRANS[1] ? ST_DATA : ST_NODATA;
         if (bus.HTRANS[1] && (dec_sel == SEL_DEF) && (decerr_q != 8'hFF))
            decerr_d = decerr_q + 8'd1;
      end
   end

   // State, select and error-count registers; reset aborts any data phase
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q  <= ST_NODATA;
         sel_q    <= SEL_DEF;
         decerr_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         decerr_q <= decerr_d;
      end
   end

   ahb_resp_mux #(.DATA_WIDTH(DATA_WIDTH)) u_resp_mux (
      .active_i        (state_q == ST_DATA),
      .sel_i           (sel_q),
      .hrdata_s0_i     (bus.HRDATA_S0),
      .hrdata_s1_i     (bus.HRDATA_S1),
      .hrdata_s2_i     (bus.HRDATA_S2),
      .hrdata_def_i    (bus.HRDATA_DEF),
      .hresp_s0_i      (bus.HRESP_S0),
      .hresp_s1_i      (bus.HRESP_S1),
      .hresp_s2_i      (bus.HRESP_S2),
      .hresp_def_i     (bus.HRESP_DEF),
      .hreadyout_s0_i  (bus.HREADYOUT_S0),
      .hreadyout_s1_i  (bus.HREADYOUT_S1),
      .hreadyout_s2_i  (bus.HREADYOUT_S2),
      .hreadyout_def_i (bus.HREADYOUT_DEF),
      .hrdata_o        (bus.HRDATA),
      .hresp_o         (bus.HRESP),
      .hready_o        (hready)
   );

   assign bus.HREADY  = hready;
   assign DECERR_CNT  = decerr_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Directed bench for ahb_decoder_mux: decode, data-phase muxing, wait states,
// default-subordinate error counting with saturation, and asynchronous reset.
module tb_ahb_decoder_mux;
   import ahb_decoder_mux_pkg::*;

   localparam logic [31:0] D_S0  = 32'h1111_0000;
   localparam logic [31:0] D_S1  = 32'hA5A5_A5A5;
   localparam logic [31:0] D_S2  = 32'h2222_2222;
   localparam logic [31:0] D_DEF = 32'hDEAD_BEEF;

   logic       HCLK;
   logic       HRESETn;
   logic [7:0] DECERR_CNT;
   state_e     dbg_state;

   int checks   = 0;
   int failures = 0;

   ahb_decoder_mux_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   ahb_decoder_mux #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .bus         (bus),
      .DECERR_CNT  (DECERR_CNT),
      .dbg_state_o (dbg_state)
   );

   // Clock
   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   // Advance to just after the next rising edge
   task automatic cyc();
      @(posedge HCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_hready"}, 64'(bus.HREADY), 64'(1'b1));
      chk({tag, "_hresp"},  64'(bus.HRESP),  64'(2'b00));
      chk({tag, "_hrdata"}, 64'(bus.HRDATA), 64'(32'h0));
   endtask

   task automatic chk_sel(input string tag, input logic [3:0] exp_def_s2_s1_s0);
      chk(tag, 64'({bus.HSEL_DEF, bus.HSEL_S2, bus.HSEL_S1, bus.HSEL_S0}),
          64'(exp_def_s2_s1_s0));
   endtask

   initial begin
      // Subordinate defaults
      bus.HADDR         = 32'h0;
      bus.HTRANS        = HTRANS_IDLE;
      bus.HRDATA_S0     = D_S0;
      bus.HRDATA_S1     = D_S1;
      bus.HRDATA_S2     = D_S2;
      bus.HRDATA_DEF    = D_DEF;
      bus.HRESP_S0      = HRESP_OKAY;
      bus.HRESP_S1      = HRESP_OKAY;
      bus.HRESP_S2      = HRESP_OKAY;
      bus.HRESP_DEF     = HRESP_ERROR;
      bus.HREADYOUT_S0  = 1'b1;
      bus.HREADYOUT_S1  = 1'b1;
      bus.HREADYOUT_S2  = 1'b1;
      bus.HREADYOUT_DEF = 1'b1;
      HRESETn = 1'b1;
      #2 HRESETn = 1'b0;
      #1;

      // Reset values
      chk_idle_outputs("rst");
      chk("rst_cnt", 64'(DECERR_CNT), 64'(8'd0));
      chk("rst_state", 64'(dbg_state), 64'(ST_NODATA));

      // Release, then three idle cycles
      cyc(); cyc();
      HRESETn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk_idle_outputs("idle");
         chk("idle_cnt", 64'(DECERR_CNT), 64'(8'd0));
      end
      chk_sel("dec_s0_idle", 4'b0001);

      // NONSEQ read to S1
      bus.HADDR  = 32'h0001_0004;
      bus.HTRANS = HTRANS_NONSEQ;
      #1;
      chk_sel("dec_s1", 4'b0010);
      chk("s1_addr_hrdata", 64'(bus.HRDATA), 64'(32'h0));
      cyc();
      bus.HADDR  = 32'h0;
      bus.HTRANS = HTRANS_IDLE;
      #1;
      chk("s1_hrdata", 64'(bus.HRDATA), 64'(D_S1));
      chk("s1_hresp",  64'(bus.HRESP),  64'(2'b00));
      chk("s1_state",  64'(dbg_state),  64'(ST_DATA));

      // NONSEQ S0 with two wait states, then NONSEQ S2
      cyc();
      bus.HADDR  = 32'h0000_0010;
      bus.HTRANS = HTRANS_NONSEQ;
      #1;
      chk("after_idle_state", 64'(dbg_state), 64'(ST_NODATA));
      chk_sel("dec_s0", 4'b0001);
      cyc();
      bus.HADDR        = 32'h0002_0000;
      bus.HREADYOUT_S0 = 1'b0;
      #1;
      chk("s0_wait1_hready", 64'(bus.HREADY), 64'(1'b0));
      chk("s0_wait1_hrdata", 64'(bus.HRDATA), 64'(D_S0));
      cyc();
      bus.HADDR = 32'h0001_0000;
      #1;
      chk_sel("dec_s1_in_wait", 4'b0010);
      chk("s0_wait2_hready", 64'(bus.HREADY), 64'(1'b0));
      chk("s0_wait2_hrdata", 64'(bus.HRDATA), 64'(D_S0));
      cyc();
      bus.HADDR        = 32'h0002_0000;
      bus.HREADYOUT_S0 = 1'b1;
      #1;
      chk("s0_done_hready", 64'(bus.HREADY), 64'(1'b1));
      chk("s0_done_hrdata", 64'(bus.HRDATA), 64'(D_S0));
      chk_sel("dec_s2", 4'b0100);
      cyc();
      bus.HADDR  = 32'h0;
      bus.HTRANS = HTRANS_IDLE;
      #1;
      chk("s2_hrdata", 64'(bus.HRDATA), 64'(D_S2));
      chk("s2_hresp",  64'(bus.HRESP),  64'(2'b00));

      // NONSEQ to the default subordinate
      cyc();
      bus.HADDR  = 32'h0005_0000;
      bus.HTRANS = HTRANS_NONSEQ;
      #1;
      chk_sel("dec_def", 4'b1000);
      chk("def_cnt_before", 64'(DECERR_CNT), 64'(8'd0));
      cyc();
      bus.HTRANS = HTRANS_IDLE;
      #1;
      chk("def_cnt_after", 64'(DECERR_CNT), 64'(8'd1));
      chk("def_hresp",     64'(bus.HRESP),  64'(2'b01));
      chk("def_hrdata",    64'(bus.HRDATA), 64'(D_DEF));

      // BUSY to default does not count
      cyc();
      bus.HADDR  = 32'hFFFF_0000;
      bus.HTRANS = HTRANS_BUSY;
      cyc();
      chk("busy_cnt", 64'(DECERR_CNT), 64'(8'd1));
      chk_idle_outputs("busy");

      // 260 back-to-back NONSEQ to default: count saturates
      bus.HTRANS = HTRANS_NONSEQ;
      for (int i = 0; i < 260; i++) begin
         cyc();
         if (i == 99) chk("sat_mid_cnt", 64'(DECERR_CNT), 64'(8'd101));
      end
      chk("sat_cnt", 64'(DECERR_CNT), 64'(8'd255));
      cyc(); cyc();
      chk("sat_hold_cnt", 64'(DECERR_CNT), 64'(8'd255));
      bus.HTRANS = HTRANS_IDLE;
      cyc(); cyc();
      chk("sat_idle_cnt", 64'(DECERR_CNT), 64'(8'd255));

      // Reset asserted during an S2 wait state
      bus.HADDR  = 32'h0002_0000;
      bus.HTRANS = HTRANS_NONSEQ;
      cyc();
      bus.HTRANS       = HTRANS_IDLE;
      bus.HREADYOUT_S2 = 1'b0;
      #1;
      chk("s2_wait_hready", 64'(bus.HREADY), 64'(1'b0));
      #2 HRESETn = 1'b0;
      #1;
      chk_idle_outputs("async_rst");
      chk("async_rst_cnt",   64'(DECERR_CNT), 64'(8'd0));
      chk("async_rst_state", 64'(dbg_state),  64'(ST_NODATA));
      cyc();
      bus.HREADYOUT_S2 = 1'b1;
      HRESETn = 1'b1;

      // First edge after release is a legal acceptance
      bus.HADDR  = 32'h0001_0000;
      bus.HTRANS = HTRANS_NONSEQ;
      cyc();
      bus.HTRANS = HTRANS_IDLE;
      #1;
      chk("post_rst_hrdata", 64'(bus.HRDATA), 64'(D_S1));
      chk("post_rst_state",  64'(dbg_state),  64'(ST_DATA));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "time limit reached");
   end

endmodule

// File: doc/ahb_decoder_mux.md
AHB_DECODER_MUX -- requirements
Module: ahb_decoder_mux

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address bus width; minimum 18.
REQ-002 Parameter DATA_WIDTH, default 32, data bus width.
REQ-003 HCLK  in  1  single system clock; all state updates on the rising edge.
REQ-004 HRESETn  in  1  reset, asynchronous assert, active-low.
REQ-005 HADDR  in  ADDR_WIDTH  manager address-phase address.
REQ-006 HTRANS  in  2  manager transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-007 HSEL_S0, HSEL_S1, HSEL_S2, HSEL_DEF  out  1 each  subordinate selects; HSEL_DEF drives ahb_default_slave.
REQ-008 HRDATA_Sx  in  DATA_WIDTH  read data from subordinate x, where x is one of S0, S1, S2, DEF.
REQ-009 HRESP_Sx  in  2  response from subordinate x.
REQ-010 HREADYOUT_Sx  in  1  ready from subordinate x.
REQ-011 HRDATA  out  DATA_WIDTH  muxed read data to the manager.
REQ-012 HRESP  out  2  muxed response to the manager.
REQ-013 HREADY  out  1  muxed ready to the manager; also fanned out as HREADYin to every subordinate.
REQ-014 DECERR_CNT  out  8  saturating count of accepted transfers decoded to the default subordinate.

Function
REQ-015 Address decode uses HADDR[ADDR_WIDTH-1:16] and is purely combinational.
  - Value 0 asserts HSEL_S0.
  - Value 1 asserts HSEL_S1.
  - Value 2 asserts HSEL_S2.
  - Any other value asserts HSEL_DEF.
REQ-016 Exactly one HSEL_* is high in every cycle, independent of HTRANS.
REQ-017 An address phase is accepted on a rising edge where HREADY=1.
REQ-018 On acceptance, the data-phase select register loads the decoded target and the data-phase-active flag loads HTRANS[1].
REQ-019 When HREADY=0, the data-phase select register and the active flag hold their values.
REQ-020 State machine:
  - Two states: NODATA and DATA.
  - NODATA to DATA: acceptance with HTRANS[1]=1.
  - DATA to NODATA: acceptance with HTRANS[1]=0.
  - DATA to DATA: acceptance with HTRANS[1]=1; the select register updates.
REQ-021 In DATA state, HRDATA, HRESP and HREADY equal the registered target's HRDATA_Sx, HRESP_Sx and HREADYOUT_Sx, combinationally, with zero added latency.
REQ-022 In NODATA state, HRDATA=0, HRESP=00 and HREADY=1.
REQ-023 Back-to-back transfers to different subordinates switch the response mux on the same edge that starts the new data phase, with no idle cycle inserted.
REQ-024 Wait states: while the selected HREADYOUT_Sx=0, the mux select is frozen, even if HADDR changes.
REQ-025 DECERR_CNT increments by 1 on each acceptance with HTRANS[1]=1 that decodes to DEF.
REQ-026 DECERR_CNT saturates at 255 and never wraps.
REQ-027 Acceptances with BUSY or IDLE (HTRANS[1]=0) never increment DECERR_CNT.

Reset
REQ-028 While HRESETn=0, the following are forced immediately, independent of HCLK:
  - State is NODATA.
  - Select register is DEF.
  - DECERR_CNT=0.
  - Hence HREADY=1, HRESP=00, HRDATA=0.
REQ-029 Reset asserted mid-wait-state aborts the data phase.
REQ-030 The first edge after deassertion with HREADY=1 is a legal acceptance.

Structure
REQ-031 Region indices, the HTRANS encodings, HRESP OKAY=00 and ERROR=01, and the region-select encoding (S0, S1, S2, DEF) live in the shared AHB subordinate defines header.
REQ-032 The combinational response multiplexer is one sub-module, ahb_resp_mux.
REQ-033 The address decoder, the state machine and the counter remain in ahb_decoder_mux.

Verification
REQ-034 Reset release, then HTRANS=IDLE for 3 cycles -> HREADY=1, HRESP=00, HRDATA=0, DECERR_CNT=0.
REQ-035 NONSEQ read at 0x0001_0004, with S1 driving HRDATA=0xA5A5_A5A5 and HREADYOUT=1 -> HSEL_S1=1 in the address cycle; next cycle HRDATA=0xA5A5_A5A5, HRESP=00.
REQ-036 NONSEQ to 0x0000_0010 (S0) followed by NONSEQ to 0x0002_0000 (S2), with S0 holding HREADYOUT_S0=0 for 2 cycles -> HREADY=0 for 2 cycles, mux stays on S0, then switches to S2 on the following edge.
REQ-037 NONSEQ to 0x0005_0000 -> HSEL_DEF=1; DECERR_CNT goes 0->1; HRESP follows HRESP_DEF (01).
REQ-038 Drive 260 consecutive accepted NONSEQ transfers to 0xFFFF_0000 -> DECERR_CNT=255 and stays 255.
REQ-039 Assert HRESETn=0 during an S2 wait state -> outputs go to reset values without an HCLK edge; DECERR_CNT=0.
